// File: rtl/safe_clock_monitor_mc_pkg.sv
// Shared types and error-code packing for the multi-channel clock monitor.
// Pure declarations: no latency, no flow control.
package safe_clkmon_pkg;

    typedef enum logic [1:0] {
        DIS    = 2'b00,
        SETTLE = 2'b01,
        MON    = 2'b10,
        FAULT  = 2'b11
    } chan_state_e;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        LOW   = 4'd1,
        HIGH  = 4'd2,
        STUCK = 4'd3
    } fault_kind_e;

    localparam logic [15:0] ERR_BASE = 16'hC002;

    function automatic logic [31:0] pack_err_code(input fault_kind_e kind, input logic [7:0] ch);
        return {ERR_BASE, 4'h0, kind, ch};
    endfunction

endpackage

// File: rtl/safe_clock_monitor_mc_if.sv
// Bundle of per-channel controls and status for the clock monitor.
// master drives configuration/monitored clocks, slave is the monitor; no handshake.
interface safe_clock_monitor_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       mon_clk_i;
    logic [NUM_CH-1:0]       ch_en_i;
    logic [NUM_CH*CNT_W-1:0] cnt_lo_i;
    logic [NUM_CH*CNT_W-1:0] cnt_hi_i;
    logic [NUM_CH-1:0]       fault_clr_i;
    logic                    scan_en_i;
    logic [NUM_CH*2-1:0]     ch_state_o;
    logic [NUM_CH*CNT_W-1:0] edge_cnt_o;
    logic [NUM_CH-1:0]       fault_o;
    logic                    fault_any_o;
    logic                    err_valid_o;
    logic [31:0]             err_code_o;

    modport master (
        output mon_clk_i, ch_en_i, cnt_lo_i, cnt_hi_i, fault_clr_i, scan_en_i,
        input  ch_state_o, edge_cnt_o, fault_o, fault_any_o, err_valid_o, err_code_o
    );

    modport slave (
        input  mon_clk_i, ch_en_i, cnt_lo_i, cnt_hi_i, fault_clr_i, scan_en_i,
        output ch_state_o, edge_cnt_o, fault_o, fault_any_o, err_valid_o, err_code_o
    );
endinterface

// File: rtl/safe_clock_monitor_mc_ch.sv
// One monitored clock: 2-flop sync, edge/stuck/debounce counters and channel FSM.
// Edge seen 3 cycles after the input rises; fault registered 1 cycle after its event; frz holds all state.
module safe_clkmon_ch
    import safe_clkmon_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int STUCK_CYCLES   = 64,
    parameter int SETTLE_WINDOWS = 2,
    parameter int FAULT_DEBOUNCE = 2
) (
    input  logic             clk_main_i,
    input  logic             rst_main_i,
    input  logic             frz,
    input  logic             win_end,
    input  logic             mon_clk,
    input  logic             ch_en,
    input  logic             fault_clr,
    input  logic [CNT_W-1:0] cnt_lo,
    input  logic [CNT_W-1:0] cnt_hi,
    output logic [1:0]       ch_state,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             fault,
    output logic             fault_enter,
    output fault_kind_e      fault_kind
);
    localparam logic [1:0] ST_DIS    = DIS;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_MON    = MON;
    localparam logic [1:0] ST_FAULT  = FAULT;

    localparam int STK_W = $clog2(STUCK_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_WINDOWS + 1);
    localparam int DEB_W = $clog2(FAULT_DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);

    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [STK_W-1:0] stk_q;
    logic [SET_W-1:0] setl_q, setl_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [1:0]       state_q, state_d;
    logic             edge_det, stuck, bad_lo, bad_hi;

    // sync_q[1] is the synchronised level, sync_q[2] its previous sample
    assign edge_det = sync_q[1] & ~sync_q[2];
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(edge_det);
    assign bad_lo   = (cnt_inc < cnt_lo);
    assign bad_hi   = !bad_lo && (cnt_inc > cnt_hi);
    assign stuck    = (stk_q == STK_MAX);

    always_comb begin
        state_d     = state_q;
        setl_d      = setl_q;
        deb_d       = deb_q;
        fault_enter = 1'b0;
        fault_kind  = NONE;
        case (state_q)
            ST_DIS: begin
                setl_d = '0;
                deb_d  = '0;
                if (ch_en) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!ch_en) begin
                    state_d = ST_DIS;
                end else if (win_end) begin
                    if (setl_q == SET_W'(SETTLE_WINDOWS - 1)) begin
                        state_d = ST_MON;
                        deb_d   = '0;
                    end else begin
                        setl_d = setl_q + 1'b1;
                    end
                end
            end
            ST_MON: begin
                // disable beats a fault; stuck beats a bad window for the reported kind
                if (!ch_en) begin
                    state_d = ST_DIS;
                end else if (stuck) begin
                    state_d     = ST_FAULT;
                    fault_enter = 1'b1;
                    fault_kind  = STUCK;
                end else if (win_end) begin
                    if (bad_lo || bad_hi) begin
                        if (deb_q == DEB_W'(FAULT_DEBOUNCE - 1)) begin
                            state_d     = ST_FAULT;
                            fault_enter = 1'b1;
                            fault_kind  = bad_lo ? LOW : HIGH;
                        end else begin
                            deb_d = deb_q + 1'b1;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
            end
            default: begin
                if (fault_clr) begin
                    state_d = ch_en ? ST_SETTLE : ST_DIS;
                    setl_d  = '0;
                    deb_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_main_i) begin
        if (rst_main_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stk_q    <= '0;
            setl_q   <= '0;
            deb_q    <= '0;
            state_q  <= ST_DIS;
            edge_cnt <= '0;
            fault    <= 1'b0;
        end else if (!frz) begin
            sync_q  <= {sync_q[1:0], mon_clk};
            state_q <= state_d;
            setl_q  <= setl_d;
            deb_q   <= deb_d;
            fault   <= (state_d == ST_FAULT);
            if (state_q == ST_DIS) begin
                cnt_q <= '0;
                stk_q <= '0;
            end else begin
                cnt_q <= win_end ? '0 : cnt_inc;
                if (win_end) edge_cnt <= cnt_inc;
                if (edge_det)      stk_q <= '0;
                else if (!stuck)   stk_q <= stk_q + 1'b1;
            end
        end
    end

    assign ch_state = state_q;

endmodule

// File: rtl/safe_clock_monitor_mc.sv
// Multi-channel clock-health monitor: shared window timer, per-channel checkers, error reporting.
// err_valid_o/err_code_o register in the same cycle fault_o rises; scan_en_i freezes everything.
module safe_clock_monitor_mc
    import safe_clkmon_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int WIN_CYCLES     = 1024,
    parameter int STUCK_CYCLES   = 64,
    parameter int SETTLE_WINDOWS = 2,
    parameter int FAULT_DEBOUNCE = 2
) (
    input  logic                   clk_main_i,
    input  logic                   rst_main_i,
    safe_clock_monitor_mc_if.slave bus
);
    localparam int WIN_W = $clog2(WIN_CYCLES);

    logic [WIN_W-1:0]        win_q;
    logic                    win_end;
    logic [NUM_CH*2-1:0]     state_w;
    logic [NUM_CH*CNT_W-1:0] edge_w;
    logic [NUM_CH-1:0]       fault_w;
    logic [NUM_CH-1:0]       enter_w;
    fault_kind_e             kind_w [NUM_CH];
    logic                    rpt_vld;
    logic [7:0]              rpt_ch;
    fault_kind_e             rpt_kind;
    logic                    err_vld_q;
    logic [31:0]             err_code_q;

    assign win_end = (win_q == WIN_W'(WIN_CYCLES - 1));

    always_ff @(posedge clk_main_i) begin
        if (rst_main_i)    win_q <= '0;
        else if (!bus.scan_en_i) win_q <= win_end ? '0 : win_q + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        safe_clkmon_ch #(
            .CNT_W          (CNT_W),
            .STUCK_CYCLES   (STUCK_CYCLES),
            .SETTLE_WINDOWS (SETTLE_WINDOWS),
            .FAULT_DEBOUNCE (FAULT_DEBOUNCE)
        ) u_ch (
            .clk_main_i  (clk_main_i),
            .rst_main_i  (rst_main_i),
            .frz         (bus.scan_en_i),
            .win_end     (win_end),
            .mon_clk     (bus.mon_clk_i[i]),
            .ch_en       (bus.ch_en_i[i]),
            .fault_clr   (bus.fault_clr_i[i]),
            .cnt_lo      (bus.cnt_lo_i[i*CNT_W +: CNT_W]),
            .cnt_hi      (bus.cnt_hi_i[i*CNT_W +: CNT_W]),
            .ch_state    (state_w[i*2 +: 2]),
            .edge_cnt    (edge_w[i*CNT_W +: CNT_W]),
            .fault       (fault_w[i]),
            .fault_enter (enter_w[i]),
            .fault_kind  (kind_w[i])
        );
    end

    // lowest index wins; other simultaneous faults only raise their fault_o bit
    always_comb begin
        rpt_vld  = 1'b0;
        rpt_ch   = '0;
        rpt_kind = NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enter_w[i]) begin
                rpt_vld  = 1'b1;
                rpt_ch   = 8'(i);
                rpt_kind = kind_w[i];
            end
        end
    end

    always_ff @(posedge clk_main_i) begin
        if (rst_main_i) begin
            err_vld_q  <= 1'b0;
            err_code_q <= '0;
        end else if (!bus.scan_en_i) begin
            err_vld_q <= rpt_vld;
            if (rpt_vld) err_code_q <= pack_err_code(rpt_kind, rpt_ch);
        end
    end

    assign bus.ch_state_o  = state_w;
    assign bus.edge_cnt_o  = edge_w;
    assign bus.fault_o     = fault_w;
    assign bus.fault_any_o = |fault_w;
    assign bus.err_valid_o = err_vld_q;
    assign bus.err_code_o  = err_code_q;

endmodule

// File: tb/tb_safe_clock_monitor_mc.sv
// Bench for safe_clock_monitor_mc: directed scenarios plus randomized clocks/bounds,
// every cycle compared against a behavioural model of the channel rules.
module tb_safe_clock_monitor_mc;
    localparam int NCH = 4, CW = 16, WIN = 1024, STK = 64, SETL = 2, DEB = 2;
    localparam int S_DIS = 0, S_SET = 1, S_MON = 2, S_FLT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_err = 0, n_pulse = 0;

    safe_clock_monitor_mc_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    safe_clock_monitor_mc #(
        .NUM_CH(NCH), .CNT_W(CW), .WIN_CYCLES(WIN), .STUCK_CYCLES(STK),
        .SETTLE_WINDOWS(SETL), .FAULT_DEBOUNCE(DEB)
    ) dut (
        .clk_main_i (clk),
        .rst_main_i (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitored clock generators ----------------
    logic [NCH-1:0] tog = '0;
    int   half[NCH] = '{4, 4, 4, 4};
    int   ph[NCH]   = '{0, 3, 6, 0};   // ch0 and ch3 share a phase
    bit   stk_mode[NCH];
    logic stk_val[NCH];

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!stk_mode[c]) begin
                ph[c]++;
                if (ph[c] >= half[c]) begin
                    ph[c]  = 0;
                    tog[c] = ~tog[c];
                end
            end
            bus.mon_clk_i[c] = stk_mode[c] ? stk_val[c] : tog[c];
        end
    end

    // ---------------- behavioural reference model ----------------
    int   m_st[NCH], m_cnt[NCH], m_out[NCH], m_stk[NCH], m_deb[NCH], m_setl[NCH];
    bit   m_h1[NCH], m_h2[NCH], m_h3[NCH];
    int   m_win;
    bit   m_vld;
    logic [31:0] m_code;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_st[c] = S_DIS; m_cnt[c] = 0; m_out[c] = 0; m_stk[c] = 0;
                m_deb[c] = 0; m_setl[c] = 0; m_h1[c] = 0; m_h2[c] = 0; m_h3[c] = 0;
            end
            m_win = 0; m_vld = 0; m_code = '0;
        end else if (!bus.scan_en_i) begin
            bit we;
            int first_ch, fkind;
            we = (m_win == WIN - 1);
            first_ch = -1; fkind = 0;
            for (int c = 0; c < NCH; c++) begin
                bit e, en, clr, stuck;
                int lo, hi, total, nxt, kind;
                e   = m_h2[c] && !m_h3[c];     // rising edge after two sync stages
                en  = bus.ch_en_i[c];
                clr = bus.fault_clr_i[c];
                lo  = int'(bus.cnt_lo_i[c*CW +: CW]);
                hi  = int'(bus.cnt_hi_i[c*CW +: CW]);
                nxt = m_st[c]; kind = 0;
                if (m_st[c] == S_DIS) begin
                    m_cnt[c] = 0; m_stk[c] = 0; m_setl[c] = 0; m_deb[c] = 0;
                    if (en) nxt = S_SET;
                end else begin
                    total = m_cnt[c] + (e ? 1 : 0);
                    if (total > 65535) total = 65535;
                    stuck = (m_stk[c] >= STK);
                    if (we) begin m_out[c] = total; m_cnt[c] = 0; end
                    else m_cnt[c] = total;
                    m_stk[c] = e ? 0 : ((m_stk[c] + 1 > STK) ? STK : m_stk[c] + 1);
                    if (!en && m_st[c] != S_FLT) nxt = S_DIS;
                    else if (m_st[c] == S_SET) begin
                        if (we) begin
                            m_setl[c]++;
                            if (m_setl[c] == SETL) begin nxt = S_MON; m_deb[c] = 0; end
                        end
                    end else if (m_st[c] == S_MON) begin
                        if (stuck) kind = 3;
                        else if (we) begin
                            if (total < lo || total > hi) begin
                                m_deb[c]++;
                                if (m_deb[c] == DEB) kind = (total < lo) ? 1 : 2;
                            end else m_deb[c] = 0;
                        end
                        if (kind != 0) nxt = S_FLT;
                    end else if (clr) begin
                        nxt = en ? S_SET : S_DIS;
                        m_setl[c] = 0; m_deb[c] = 0;
                    end
                end
                if (kind != 0 && first_ch < 0) begin first_ch = c; fkind = kind; end
                m_st[c] = nxt;
                m_h3[c] = m_h2[c]; m_h2[c] = m_h1[c]; m_h1[c] = bus.mon_clk_i[c];
            end
            m_vld = (first_ch >= 0);
            if (m_vld) m_code = {16'hC002, 4'h0, 4'(fkind), 8'(first_ch)};
            m_win = (m_win + 1) % WIN;
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [NCH*2-1:0]  es;
    logic [NCH-1:0]    ef;
    logic [NCH*CW-1:0] ee;

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            es[c*2 +: 2]  = 2'(m_st[c]);
            ef[c]         = (m_st[c] == S_FLT);
            ee[c*CW +: CW] = CW'(m_out[c]);
        end
        chk("ch_state", 64'(bus.ch_state_o), 64'(es));
        chk("fault", 64'({bus.fault_any_o, bus.fault_o}), 64'({|ef, ef}));
        chk("err_valid", 64'(bus.err_valid_o), 64'(m_vld));
        chk("err_code", 64'(bus.err_code_o), 64'(m_code));
        chk("edge_cnt", 64'(bus.edge_cnt_o), 64'(ee));
        if (bus.err_valid_o === 1'b1) n_pulse++;
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_bounds(input int c, input int lo, input int hi);
        bus.cnt_lo_i[c*CW +: CW] = CW'(lo);
        bus.cnt_hi_i[c*CW +: CW] = CW'(hi);
    endtask

    initial begin
        int k, p0;
        bus.ch_en_i = '0; bus.fault_clr_i = '0; bus.scan_en_i = 1'b0;
        for (int c = 0; c < NCH; c++) set_bounds(c, 120, 136);
        run(3);
        chk("rst_state", 64'(bus.ch_state_o), 64'(0));
        chk("rst_outs", 64'({bus.fault_any_o, bus.fault_o, bus.err_valid_o, bus.edge_cnt_o}), 64'(0));
        chk("rst_code", 64'(bus.err_code_o), 64'(0));
        rst = 1'b0;
        bus.ch_en_i = 4'hF;

        // nominal clocks at f_main/8 settle into MON with 128 edges per window
        run(3 * WIN + 20);
        chk("t1_state", 64'(bus.ch_state_o), 64'(8'b1010_1010));
        for (int c = 0; c < NCH; c++) chk("t1_edges", 64'(bus.edge_cnt_o[c*CW +: CW]), 64'(128));
        chk("t1_pulses", 64'(n_pulse), 64'(0));

        // ch1 too fast
        half[1] = 2;
        run(3 * WIN);
        chk("t2_fault", 64'(bus.fault_o), 64'(4'b0010));
        chk("t2_code", 64'(bus.err_code_o), 64'(32'hC002_0201));
        chk("t2_pulses", 64'(n_pulse), 64'(1));

        // ch2 stuck low
        stk_mode[2] = 1'b1; stk_val[2] = 1'b0;
        k = 0;
        while (!bus.fault_o[2] && k < 200) begin run(1); k++; end
        chk("t3_latency_ok", 64'(k >= 60 && k <= 68), 64'(1));
        chk("t3_code", 64'(bus.err_code_o), 64'(32'hC002_0302));
        run(3);
        chk("t3_pulses", 64'(n_pulse), 64'(2));

        // clear ch1 back to SETTLE, then MON after two window ends
        half[1] = 4;
        run(20);
        bus.fault_clr_i = 4'b0010;
        run(1);
        bus.fault_clr_i = '0;
        chk("t5_fault1", 64'(bus.fault_o[1]), 64'(0));
        chk("t5_settle", 64'(bus.ch_state_o[3:2]), 64'(S_SET));
        run(2 * WIN + 10);
        chk("t5_mon", 64'(bus.ch_state_o[3:2]), 64'(S_MON));
        bus.ch_en_i[2] = 1'b0; bus.fault_clr_i = 4'b0100;
        run(1);
        bus.fault_clr_i = '0;
        chk("t5_dis", 64'(bus.ch_state_o[5:4]), 64'(S_DIS));

        // ch0 and ch3 stuck from the same cycle: one report, lowest index
        p0 = n_pulse;
        stk_mode[0] = 1'b1; stk_val[0] = 1'b0;
        stk_mode[3] = 1'b1; stk_val[3] = 1'b0;
        k = 0;
        while (!(bus.fault_o[0] || bus.fault_o[3]) && k < 200) begin run(1); k++; end
        chk("t4_fault", 64'(bus.fault_o), 64'(4'b1001));
        chk("t4_code", 64'(bus.err_code_o), 64'(32'hC002_0300));
        run(3);
        chk("t4_pulses", 64'(n_pulse - p0), 64'(1));

        // recover all channels, then freeze with every clock stuck
        for (int c = 0; c < NCH; c++) stk_mode[c] = 1'b0;
        bus.ch_en_i = 4'hF; bus.fault_clr_i = 4'hF;
        run(1);
        bus.fault_clr_i = '0;
        run(2 * WIN + 300);
        chk("t6_mon", 64'(bus.ch_state_o), 64'(8'b1010_1010));
        bus.scan_en_i = 1'b1;
        for (int c = 0; c < NCH; c++) begin stk_mode[c] = 1'b1; stk_val[c] = 1'($urandom_range(0, 1)); end
        run(500);
        chk("t6_nofault", 64'(bus.fault_o), 64'(0));
        chk("t6_frozen", 64'(bus.ch_state_o), 64'(8'b1010_1010));
        for (int c = 0; c < NCH; c++) stk_mode[c] = 1'b0;
        bus.scan_en_i = 1'b0;
        run(300);

        // reset mid-window
        rst = 1'b1;
        run(1);
        chk("t6_rst_outs", 64'({bus.ch_state_o, bus.fault_o, bus.fault_any_o, bus.err_valid_o}), 64'(0));
        chk("t6_rst_edges", 64'(bus.edge_cnt_o), 64'(0));
        chk("t6_rst_code", 64'(bus.err_code_o), 64'(0));
        rst = 1'b0;
        // first window end is cycle 1023 after release; edge_cnt_o loads on the following edge
        k = 0;
        while (bus.edge_cnt_o[CW-1:0] == '0 && k < 2000) begin run(1); k++; end
        chk("t6_first_win", 64'(k), 64'(1024));

        // randomized clocks, bounds, enables, clears and short freezes
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < NCH; c++) begin
                int ex, lo, hi;
                half[c] = $urandom_range(2, 8);
                stk_mode[c] = ($urandom_range(0, 5) == 0);
                stk_val[c]  = 1'($urandom_range(0, 1));
                ex = WIN / (2 * half[c]);
                lo = ex - $urandom_range(0, 8);
                hi = ex + $urandom_range(0, 8);
                if ($urandom_range(0, 5) == 0) begin lo = ex + 5; hi = ex - 5; end
                set_bounds(c, lo, hi);
                bus.ch_en_i[c] = ($urandom_range(0, 7) != 0);
            end
            for (int q = 0; q < 4; q++) begin
                run($urandom_range(200, 300));
                if ($urandom_range(0, 1) == 1) begin
                    bus.fault_clr_i = 4'($urandom_range(0, 15));
                    run(1);
                    bus.fault_clr_i = '0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    bus.scan_en_i = 1'b1;
                    run($urandom_range(1, 50));
                    bus.scan_en_i = 1'b0;
                end
            end
        end

        run(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/safe_clock_monitor_mc.md
Name: safe_clock_monitor_mc

Overview:
Multi-channel clock-health monitor for the safety island, ASIL-D. Checks NUM_CH asynchronous clocks against per-channel frequency windows and a stuck-clock timeout. Runs entirely in the main reference clock domain. Latches sticky per-channel faults and reports a coded safety error to the safety manager. Successor to the single-channel stability check: adds runtime frequency bounds, fault debounce, a per-channel FSM and a fault-clear handshake.

Parameters:
NUM_CH, 4, number of monitored clocks
CNT_W, 16, width of edge counters and bounds
WIN_CYCLES, 1024, measurement window length in clk_main_i cycles
STUCK_CYCLES, 64, number of cycles without a rising edge that declares a stuck clock
SETTLE_WINDOWS, 2, number of windows ignored after enable or clear
FAULT_DEBOUNCE, 2, consecutive out-of-range windows required to raise a fault

Ports:
clk_main_i  in  1  reference clock; the only clock
rst_main_i  in  1  synchronous, active-high reset
mon_clk_i  in  NUM_CH  monitored clocks, sampled as data
ch_en_i  in  NUM_CH  per-channel enable
cnt_lo_i  in  NUM_CH*CNT_W  minimum edges per window
cnt_hi_i  in  NUM_CH*CNT_W  maximum edges per window
fault_clr_i  in  NUM_CH  one-cycle clear request
scan_en_i  in  1  freezes all monitoring
ch_state_o  out  NUM_CH*2  per-channel FSM state
edge_cnt_o  out  NUM_CH*CNT_W  edge count of the last completed window
fault_o  out  NUM_CH  sticky per-channel fault
fault_any_o  out  1  OR of fault_o
err_valid_o  out  1  one-cycle pulse for a new fault
err_code_o  out  32  last reported error code

Behaviour:
- Reset (rst_main_i=1 at a clk_main_i edge):
  - All outputs 0.
  - All channels go to DIS.
  - Window counter, synchronisers and edge, stuck and debounce counters are cleared.
- Sampling:
  - Each mon_clk_i passes through a 2-flop synchroniser.
  - A rising edge is counted when the synchronised value is 1 and the previous sample is 0.
  - Valid only when f_mon < f_main/2.
- Window:
  - A shared counter runs 0..WIN_CYCLES-1 and wraps.
  - win_end is asserted when the count equals WIN_CYCLES-1; the first win_end is WIN_CYCLES-1 cycles after reset release.
- Edge counter:
  - Saturates at 2^CNT_W-1.
  - On win_end the count, including any edge in that cycle, loads into edge_cnt_o and the counter restarts at 0.
- Window verdict: bad_lo if count < lo; else bad_hi if count > hi; else good. If lo > hi, every window is bad.
- Stuck counter: clears on each edge and saturates at STUCK_CYCLES. Reaching STUCK_CYCLES sets stuck.
- FSM per channel:
  - DIS=00: counters held at 0. When ch_en=1, go to SETTLE.
  - SETTLE=01: ignores verdicts and stuck. Go to MON after SETTLE_WINDOWS win_end pulses.
  - MON=10: a bad window increments the debounce counter and a good window clears it. Debounce reaching FAULT_DEBOUNCE, or stuck, goes to FAULT.
  - FAULT=11: sticky. ch_en=0 does not leave FAULT.
  - fault_clr_i in FAULT: go to SETTLE if ch_en=1, else DIS. fault_clr_i is ignored in other states.
  - ch_en=0 in SETTLE or MON: go to DIS on the next cycle.
- fault_o[i] = (state==FAULT), registered. It asserts the cycle after the triggering win_end or stuck event, and deasserts the cycle after the clear.
- Error code: err_code_o = {16'hC002, 4'h0, kind[3:0], ch[7:0]}, with kind 1=low, 2=high, 3=stuck.
  - If stuck and a bad window happen in the same cycle, stuck is reported.
- err_valid_o pulses for one cycle, in the same cycle fault_o rises.
  - If several channels enter FAULT in the same cycle, report the lowest index; the others set fault_o without a code.
  - err_code_o holds until the next report or reset.
- scan_en_i=1 freezes all counters, FSMs and outputs; no events occur. Sampling resumes from the held state when scan_en_i returns to 0.
- Reset mid-window: everything restarts and the partial count is discarded.

Decomposition:
- Package safe_clkmon_pkg:
  - chan_state_e {DIS, SETTLE, MON, FAULT}
  - fault_kind_e {NONE=0, LOW=1, HIGH=2, STUCK=3}
  - ERR_BASE=16'hC002
  - function pack_err_code(kind, ch)
- Sub-module safe_clkmon_ch, instantiated NUM_CH times: synchroniser, edge detect, edge, stuck and debounce counters, FSM. Inputs are win_end and frz.
- The top level holds the window counter, the lowest-index arbiter and the error registers.

Test Plan:
1. Defaults, all ch_en=1, mon clocks at f_main/8, lo=120, hi=136. After 2 windows ch_state=MON; edge_cnt_o=128 on every channel; no fault, err_valid_o never pulses.
2. ch1 switched to f_main/4 (256 edges) while in MON. fault_o[1] rises after the 2nd consecutive bad window; err_code_o=32'hC002_0201; err_valid_o high for exactly 1 cycle.
3. ch2 held at 0 in MON. fault_o[2] rises within 64+3 cycles of the last edge; err_code_o=32'hC002_0302.
4. ch0 and ch3 stuck from the same cycle. fault_o=4'b1001; a single err_valid_o pulse with code 32'hC002_0300.
5. After test 2, restore ch1 and pulse fault_clr_i[1]. fault_o[1]=0 next cycle; state SETTLE, then MON after 2 win_end pulses. With ch_en[1]=0, clear goes to DIS.
6. scan_en_i=1 for 500 cycles mid-window: outputs frozen, no fault despite stuck clocks. Separately, rst_main_i pulsed mid-window: all outputs 0 next cycle and the first win_end arrives 1023 cycles after release.
